// File: rtl/inst_feeder_pkg.sv
// Shared types for the instruction feeder: fetch entry layout, FTQ tag types,
// feeder mode and FSM state encodings.
package inst_feeder_pkg;

  localparam int unsigned FEED_FTQ_SIZE = 8;
  localparam int unsigned FEED_FTQ_BLK  = 8;

  typedef logic [$clog2(FEED_FTQ_SIZE)-1:0] ftqIdx_t;
  typedef logic [$clog2(FEED_FTQ_BLK)-1:0]  ftqOffset_t;

  typedef struct packed {
    logic [31:0] inst;
    ftqIdx_t     ftq_idx;
    ftqOffset_t  ftqOffset;
    logic        has_except;
    logic [3:0]  except;
  } fetchEntry_t;

  typedef enum logic [1:0] {
    FEED_CONST = 2'd0,
    FEED_PROG  = 2'd1
  } feed_mode_e;

  typedef enum logic [1:0] {
    FEED_IDLE = 2'd0,
    FEED_RUN  = 2'd1,
    FEED_DONE = 2'd2
  } feed_state_e;

  // Round v up to the next multiple of m (32-bit wrap, like seq itself).
  function automatic logic [31:0] feed_ceil_mult(input logic [31:0] v, input int unsigned m);
    return ((v + 32'(m) - 32'd1) / 32'(m)) * 32'(m);
  endfunction

endpackage

// File: rtl/inst_feeder_mem.sv
// Program memory: one write port, WIDTH combinational read ports at
// consecutive addresses from raddr, wrapping modulo DEPTH.
module inst_feeder_mem #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [$clog2(DEPTH)-1:0]      waddr,
  input  logic [31:0]                   wdata,
  input  logic [$clog2(DEPTH)-1:0]      raddr,
  output logic [WIDTH-1:0][31:0]        rdata
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [31:0] mem [DEPTH];

  // Not reset: contents survive rst so a bench can load once and restart.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  for (genvar k = 0; k < WIDTH; k++) begin : g_rd
    assign rdata[k] = mem[raddr + AW'(k)];
  end

endmodule

// File: rtl/inst_feeder.sv
// Parametrised instruction-stream source driving up to WIDTH fetch entries per
// cycle, with const/program modes, backpressure, squash and an issue budget.
module inst_feeder
  import inst_feeder_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned FTQ_SIZE = FEED_FTQ_SIZE,
  parameter int unsigned FTQ_BLK  = FEED_FTQ_BLK
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    i_mode,
  input  logic [31:0]                   i_const_inst,
  input  logic                          i_start,
  input  logic [31:0]                   i_total,
  input  logic [$clog2(WIDTH):0]        i_lane_cnt,
  input  logic                          i_prog_we,
  input  logic [$clog2(DEPTH)-1:0]      i_prog_waddr,
  input  logic [31:0]                   i_prog_wdata,
  input  logic                          i_stall,
  input  logic                          i_squash,
  input  logic [$clog2(DEPTH)-1:0]      i_squash_idx,
  output logic [WIDTH-1:0]              o_inst_vld,
  output fetchEntry_t [WIDTH-1:0]       o_inst,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [31:0]                   o_issued_cnt
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(WIDTH) + 1;

  feed_state_e              state, state_nxt;
  logic [AW-1:0]            pc, pc_nxt;
  logic [31:0]              seq, seq_nxt, issued, issued_nxt, remaining;
  logic [LW-1:0]            cur_n, lanes, n;
  logic                     acc, done_hit, load;
  logic [WIDTH-1:0]         vld_new;
  fetchEntry_t [WIDTH-1:0]  ent_new;
  logic [WIDTH-1:0][31:0]   rdata;

  // Counters advance by the size of the bundle being accepted this cycle;
  // the next bundle is built from these post-acceptance values.
  assign acc        = (state == FEED_RUN) && (|o_inst_vld) && !i_stall && !i_squash;
  assign issued_nxt = issued + (acc ? 32'(cur_n) : 32'd0);
  assign seq_nxt    = seq + (acc ? 32'(cur_n) : 32'd0);
  assign pc_nxt     = pc + (acc ? AW'(cur_n) : AW'(0));
  assign done_hit   = (i_total != 32'd0) && (issued_nxt >= i_total);
  assign remaining  = i_total - issued_nxt;
  assign load       = !(|o_inst_vld) || acc;
  assign o_issued_cnt = issued;

  always_comb begin
    lanes = i_lane_cnt;
    if (i_lane_cnt == '0)               lanes = LW'(1);
    else if (i_lane_cnt > LW'(WIDTH))   lanes = LW'(WIDTH);
  end

  assign n = ((i_total != 32'd0) && (remaining < 32'(lanes))) ? LW'(remaining) : lanes;

  inst_feeder_mem #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_mem (
    .clk   (clk),
    .we    (i_prog_we),
    .waddr (i_prog_waddr),
    .wdata (i_prog_wdata),
    .raddr (pc_nxt),
    .rdata (rdata)
  );

  for (genvar k = 0; k < WIDTH; k++) begin : g_lane
    logic [31:0] s;
    fetchEntry_t e;
    assign s          = seq_nxt + 32'(k);
    assign vld_new[k] = LW'(k) < n;
    always_comb begin
      e = '0;
      if (vld_new[k]) begin
        e.inst      = (i_mode == FEED_PROG) ? rdata[k] : i_const_inst;
        e.ftq_idx   = ftqIdx_t'((s / FTQ_BLK) % FTQ_SIZE);
        e.ftqOffset = ftqOffset_t'(s % FTQ_BLK);
      end
    end
    assign ent_new[k] = e;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= FEED_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FEED_IDLE: if (i_start) state_nxt = FEED_RUN;
      FEED_RUN:  if (!i_start && !i_squash && done_hit) state_nxt = FEED_DONE;
      FEED_DONE: if (i_start) state_nxt = FEED_RUN;
      default:   state_nxt = FEED_IDLE;
    endcase
  end

  always_comb begin
    o_busy = (state == FEED_RUN);
    o_done = (state == FEED_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst || i_start) begin
      pc         <= '0;
      seq        <= '0;
      issued     <= '0;
      cur_n      <= '0;
      o_inst_vld <= '0;
      o_inst     <= '0;
    end else if (state == FEED_RUN) begin
      if (i_squash) begin
        o_inst_vld <= '0;
        o_inst     <= '0;
        cur_n      <= '0;
        pc         <= i_squash_idx;
        seq        <= feed_ceil_mult(seq, FTQ_BLK);
      end else if (done_hit) begin
        o_inst_vld <= '0;
        o_inst     <= '0;
        cur_n      <= '0;
        pc         <= pc_nxt;
        seq        <= seq_nxt;
        issued     <= issued_nxt;
      end else if (load) begin
        pc         <= pc_nxt;
        seq        <= seq_nxt;
        issued     <= issued_nxt;
        cur_n      <= n;
        o_inst_vld <= vld_new;
        o_inst     <= ent_new;
      end
    end
  end

endmodule

// File: tb/tb_inst_feeder.sv
// Directed bench for inst_feeder: const/prog modes, budget, stall, squash,
// restart and reset-in-run.
module tb_inst_feeder;
  import inst_feeder_pkg::*;

  localparam int W = 4;
  localparam int D = 64;
  typedef fetchEntry_t [W-1:0] bundle_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  i_mode;
  logic [31:0] i_const_inst;
  logic        i_start;
  logic [31:0] i_total;
  logic [2:0]  i_lane_cnt;
  logic        i_prog_we;
  logic [5:0]  i_prog_waddr;
  logic [31:0] i_prog_wdata;
  logic        i_stall;
  logic        i_squash;
  logic [5:0]  i_squash_idx;
  logic [W-1:0] o_inst_vld;
  bundle_t     o_inst;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_issued_cnt;

  int total = 0;
  int bad   = 0;
  localparam logic [31:0] CI = 32'h001080B3;

  inst_feeder #(.WIDTH(W), .DEPTH(D), .FTQ_SIZE(8), .FTQ_BLK(8)) dut (
    .clk(clk), .rst(rst), .i_mode(i_mode), .i_const_inst(i_const_inst),
    .i_start(i_start), .i_total(i_total), .i_lane_cnt(i_lane_cnt),
    .i_prog_we(i_prog_we), .i_prog_waddr(i_prog_waddr), .i_prog_wdata(i_prog_wdata),
    .i_stall(i_stall), .i_squash(i_squash), .i_squash_idx(i_squash_idx),
    .o_inst_vld(o_inst_vld), .o_inst(o_inst), .o_busy(o_busy), .o_done(o_done),
    .o_issued_cnt(o_issued_cnt)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk); #1;
  endtask

  function automatic logic [W-1:0] mask(input int n);
    logic [7:0] m;
    m = 8'((1 << n) - 1);
    return m[W-1:0];
  endfunction

  // Expected bundle: n valid lanes; prog lanes carry (base+k) mod 64 since mem[i]=i.
  function automatic bundle_t exp_b(input int n, input logic [31:0] base, input bit prog,
                                    input logic [31:0] seq);
    bundle_t b;
    logic [31:0] s;
    b = '0;
    for (int k = 0; k < n; k++) begin
      s = seq + 32'(k);
      b[k].inst      = prog ? ((base + 32'(k)) % 32'd64) : base;
      b[k].ftq_idx   = ftqIdx_t'((s / 32'd8) % 32'd8);
      b[k].ftqOffset = ftqOffset_t'(s % 32'd8);
    end
    return b;
  endfunction

  task automatic test_reset;
    rst = 1'b1; i_mode = 2'd0; i_const_inst = '0; i_start = 1'b0; i_total = '0;
    i_lane_cnt = 3'd1; i_prog_we = 1'b0; i_prog_waddr = '0; i_prog_wdata = '0;
    i_stall = 1'b0; i_squash = 1'b0; i_squash_idx = '0;
    step; step;
    total++;
    if ({o_inst_vld, o_inst, o_busy, o_done, o_issued_cnt} !== '0) begin
      bad++; $display("FAIL reset_outputs got vld=%b busy=%b done=%b cnt=%0d inst=%h exp all zero",
                      o_inst_vld, o_busy, o_done, o_issued_cnt, o_inst);
    end
    rst = 1'b0;
    step;
    total++;
    if ({o_busy, o_done, o_inst_vld} !== '0) begin
      bad++; $display("FAIL idle_hold got busy=%b done=%b vld=%b exp 0", o_busy, o_done, o_inst_vld);
    end
  endtask

  task automatic test_const_single;
    i_mode = 2'd0; i_const_inst = CI; i_lane_cnt = 3'd1; i_total = 32'd5; i_start = 1'b1;
    step; i_start = 1'b0;
    total++;
    if ({o_inst_vld, o_busy} !== 5'b0000_1) begin
      bad++; $display("FAIL c1_enter got vld=%b busy=%b exp vld=0 busy=1", o_inst_vld, o_busy);
    end
    for (int i = 0; i < 5; i++) begin
      step;
      total++;
      if (o_inst_vld !== 4'b0001 || o_inst !== exp_b(1, CI, 1'b0, 32'(i))) begin
        bad++; $display("FAIL c1_bundle[%0d] got vld=%b inst=%h exp vld=0001 inst=%h",
                        i, o_inst_vld, o_inst, exp_b(1, CI, 1'b0, 32'(i)));
      end
      total++;
      if (o_issued_cnt !== 32'(i)) begin
        bad++; $display("FAIL c1_cnt[%0d] got %0d exp %0d", i, o_issued_cnt, i);
      end
    end
    step;
    total++;
    if ({o_done, o_busy, o_inst_vld} !== 6'b10_0000 || o_issued_cnt !== 32'd5) begin
      bad++; $display("FAIL c1_done got done=%b busy=%b vld=%b cnt=%0d exp done=1 busy=0 vld=0 cnt=5",
                      o_done, o_busy, o_inst_vld, o_issued_cnt);
    end
    step;
    total++;
    if (o_done !== 1'b1 || o_issued_cnt !== 32'd5) begin
      bad++; $display("FAIL c1_frozen got done=%b cnt=%0d exp done=1 cnt=5", o_done, o_issued_cnt);
    end
  endtask

  task automatic test_const_multi;
    int nn [3] = '{4, 4, 2};
    int ss [3] = '{0, 4, 8};
    i_lane_cnt = 3'd4; i_total = 32'd10; i_start = 1'b1;
    step; i_start = 1'b0;
    total++;
    if ({o_inst_vld, o_busy, o_done, o_issued_cnt} !== {4'b0, 1'b1, 1'b0, 32'd0}) begin
      bad++; $display("FAIL c4_restart got vld=%b busy=%b done=%b cnt=%0d exp vld=0 busy=1 done=0 cnt=0",
                      o_inst_vld, o_busy, o_done, o_issued_cnt);
    end
    for (int b = 0; b < 3; b++) begin
      step;
      total++;
      if (o_inst_vld !== mask(nn[b]) || o_inst !== exp_b(nn[b], CI, 1'b0, 32'(ss[b])) ||
          o_issued_cnt !== 32'(ss[b])) begin
        bad++; $display("FAIL c4_bundle[%0d] got vld=%b cnt=%0d inst=%h exp vld=%b cnt=%0d inst=%h",
                        b, o_inst_vld, o_issued_cnt, o_inst, mask(nn[b]), ss[b],
                        exp_b(nn[b], CI, 1'b0, 32'(ss[b])));
      end
    end
    step;
    total++;
    if ({o_done, o_inst_vld} !== 5'b1_0000 || o_issued_cnt !== 32'd10) begin
      bad++; $display("FAIL c4_done got done=%b vld=%b cnt=%0d exp done=1 vld=0 cnt=10",
                      o_done, o_inst_vld, o_issued_cnt);
    end
  endtask

  task automatic test_reserved_mode;
    i_mode = 2'd3; i_lane_cnt = 3'd0; i_total = 32'd0; i_start = 1'b1;
    step; i_start = 1'b0;
    step;
    total++;
    if (o_inst_vld !== 4'b0001 || o_inst !== exp_b(1, CI, 1'b0, 32'd0)) begin
      bad++; $display("FAIL rsv_lane0 got vld=%b inst=%h exp vld=0001 inst=%h",
                      o_inst_vld, o_inst, exp_b(1, CI, 1'b0, 32'd0));
    end
    step;
    total++;
    if (o_inst !== exp_b(1, CI, 1'b0, 32'd1) || o_issued_cnt !== 32'd1) begin
      bad++; $display("FAIL rsv_next got cnt=%0d inst=%h exp cnt=1 inst=%h",
                      o_issued_cnt, o_inst, exp_b(1, CI, 1'b0, 32'd1));
    end
  endtask

  task automatic test_prog_wrap;
    for (int i = 0; i < D; i++) begin
      i_prog_we = 1'b1; i_prog_waddr = 6'(i); i_prog_wdata = 32'(i);
      step;
    end
    i_prog_we = 1'b0;
    i_mode = 2'd1; i_lane_cnt = 3'd4; i_total = 32'd0; i_start = 1'b1;
    step; i_start = 1'b0;
    step;
    total++;
    if (o_inst_vld !== 4'b1111 || o_inst !== exp_b(4, 0, 1'b1, 0)) begin
      bad++; $display("FAIL prog_first got vld=%b inst=%h exp vld=1111 inst=%h",
                      o_inst_vld, o_inst, exp_b(4, 0, 1'b1, 0));
    end
    i_squash = 1'b1; i_squash_idx = 6'd62;
    step; i_squash = 1'b0;
    total++;
    if (o_inst_vld !== 4'b0000 || o_issued_cnt !== 32'd0) begin
      bad++; $display("FAIL prog_sq_gap got vld=%b cnt=%0d exp vld=0000 cnt=0", o_inst_vld, o_issued_cnt);
    end
    step;
    total++;
    if (o_inst_vld !== 4'b1111 || o_inst !== exp_b(4, 62, 1'b1, 0)) begin
      bad++; $display("FAIL prog_wrap got vld=%b inst=%h exp vld=1111 inst=%h",
                      o_inst_vld, o_inst, exp_b(4, 62, 1'b1, 0));
    end
  endtask

  task automatic test_stall;
    i_stall = 1'b1; i_lane_cnt = 3'd2;
    for (int i = 0; i < 3; i++) begin
      step;
      total++;
      if (o_inst_vld !== 4'b1111 || o_inst !== exp_b(4, 62, 1'b1, 0) || o_issued_cnt !== 32'd0) begin
        bad++; $display("FAIL stall_hold[%0d] got vld=%b cnt=%0d inst=%h exp vld=1111 cnt=0 inst=%h",
                        i, o_inst_vld, o_issued_cnt, o_inst, exp_b(4, 62, 1'b1, 0));
      end
    end
    i_stall = 1'b0;
    step;
    total++;
    if (o_inst_vld !== 4'b0011 || o_inst !== exp_b(2, 2, 1'b1, 4) || o_issued_cnt !== 32'd4) begin
      bad++; $display("FAIL stall_resume got vld=%b cnt=%0d inst=%h exp vld=0011 cnt=4 inst=%h",
                      o_inst_vld, o_issued_cnt, o_inst, exp_b(2, 2, 1'b1, 4));
    end
    i_lane_cnt = 3'd4;
  endtask

  task automatic test_squash;
    i_start = 1'b1;
    step; i_start = 1'b0;
    total++;
    if (o_inst_vld !== 4'b0000 || o_issued_cnt !== 32'd0) begin
      bad++; $display("FAIL sq_restart got vld=%b cnt=%0d exp vld=0000 cnt=0", o_inst_vld, o_issued_cnt);
    end
    step; step; step;
    total++;
    if (o_inst !== exp_b(4, 8, 1'b1, 8) || o_issued_cnt !== 32'd8) begin
      bad++; $display("FAIL sq_seq8 got cnt=%0d inst=%h exp cnt=8 inst=%h",
                      o_issued_cnt, o_inst, exp_b(4, 8, 1'b1, 8));
    end
    i_lane_cnt = 3'd1;
    step; step;
    total++;
    if (o_inst_vld !== 4'b0001 || o_inst !== exp_b(1, 13, 1'b1, 13) || o_issued_cnt !== 32'd13) begin
      bad++; $display("FAIL sq_seq13 got vld=%b cnt=%0d inst=%h exp vld=0001 cnt=13 inst=%h",
                      o_inst_vld, o_issued_cnt, o_inst, exp_b(1, 13, 1'b1, 13));
    end
    i_squash = 1'b1; i_squash_idx = 6'd20; i_stall = 1'b1;
    step; i_squash = 1'b0; i_stall = 1'b0; i_lane_cnt = 3'd4;
    total++;
    if (o_inst_vld !== 4'b0000 || o_issued_cnt !== 32'd13) begin
      bad++; $display("FAIL sq_gap got vld=%b cnt=%0d exp vld=0000 cnt=13", o_inst_vld, o_issued_cnt);
    end
    step;
    total++;
    if (o_inst_vld !== 4'b1111 || o_inst !== exp_b(4, 20, 1'b1, 16) || o_issued_cnt !== 32'd13) begin
      bad++; $display("FAIL sq_fresh got vld=%b cnt=%0d inst=%h exp vld=1111 cnt=13 inst=%h",
                      o_inst_vld, o_issued_cnt, o_inst, exp_b(4, 20, 1'b1, 16));
    end
  endtask

  task automatic test_start_squash;
    i_start = 1'b1; i_squash = 1'b1; i_squash_idx = 6'd40;
    step; i_start = 1'b0; i_squash = 1'b0;
    step;
    total++;
    if (o_inst !== exp_b(4, 0, 1'b1, 0) || o_issued_cnt !== 32'd0) begin
      bad++; $display("FAIL start_wins got cnt=%0d inst=%h exp cnt=0 inst=%h",
                      o_issued_cnt, o_inst, exp_b(4, 0, 1'b1, 0));
    end
  endtask

  task automatic test_reset_run;
    rst = 1'b1;
    step; rst = 1'b0;
    total++;
    if ({o_inst_vld, o_inst, o_busy, o_done, o_issued_cnt} !== '0) begin
      bad++; $display("FAIL rst_run got vld=%b busy=%b done=%b cnt=%0d inst=%h exp all zero",
                      o_inst_vld, o_busy, o_done, o_issued_cnt, o_inst);
    end
    i_start = 1'b1;
    step; i_start = 1'b0;
    step;
    total++;
    if (o_inst_vld !== 4'b1111 || o_inst !== exp_b(4, 0, 1'b1, 0)) begin
      bad++; $display("FAIL rst_restart got vld=%b inst=%h exp vld=1111 inst=%h",
                      o_inst_vld, o_inst, exp_b(4, 0, 1'b1, 0));
    end
    step;
    total++;
    if (o_inst !== exp_b(4, 4, 1'b1, 4) || o_issued_cnt !== 32'd4) begin
      bad++; $display("FAIL rst_next got cnt=%0d inst=%h exp cnt=4 inst=%h",
                      o_issued_cnt, o_inst, exp_b(4, 4, 1'b1, 4));
    end
  endtask

  initial begin
    test_reset;
    test_const_single;
    test_const_multi;
    test_reserved_mode;
    test_prog_wrap;
    test_stall;
    test_squash;
    test_start_squash;
    test_reset_run;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
